sram_bridge: RTL and testbench

- Memory-side stage between the MMU and the on-chip SRAM macro.
- Accepts single word-aligned requests on the vector-processor memory interface: req/addr/we/be/wdata out, rvalid/err/rdata back.
- Converts each request into a byte-masked SRAM macro access and waits the macro's fixed read latency.
- Returns exactly one response per granted request; at most one transaction is outstanding.

---
 rtl/sram_bridge.sv | 172 +++++++++++++++++
 tb/tb_sram_bridge.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_bridge.sv
// sram_bridge: single-outstanding bridge from the vector-processor memory
// request interface to a byte-masked on-chip SRAM macro with fixed read latency.
// Optional build macro: SRAM_BRIDGE_PARITY_EN adds one even-parity bit per data
// byte to the macro word, written on stores and checked on enabled bytes of loads.
//
// Handshake: a request is presented by holding req_i with stable fields until
// gnt_o is seen; gnt_o is combinational (req_i while IDLE) and the fields are
// captured on that clock edge. Each grant yields exactly one single-cycle
// rvalid_o pulse; there is no response backpressure.
module sram_bridge #(
    parameter int                ADDR_W    = 32,
    parameter int                DATA_W    = 32,
    parameter int                SRAM_AW   = 10,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int                SRAM_LAT  = 1,
`ifdef SRAM_BRIDGE_PARITY_EN
    localparam int               MW        = DATA_W + DATA_W/8
`else
    localparam int               MW        = DATA_W
`endif
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_i,
    output logic                gnt_o,
    input  logic [ADDR_W-1:0]   addr_i,
    input  logic                we_i,
    input  logic [DATA_W/8-1:0] be_i,
    input  logic [DATA_W-1:0]   wdata_i,
    output logic                rvalid_o,
    output logic                err_o,
    output logic [DATA_W-1:0]   rdata_o,
    output logic                sram_ce_o,
    output logic                sram_we_o,
    output logic [SRAM_AW-1:0]  sram_addr_o,
    output logic [MW-1:0]       sram_wmask_o,
    output logic [MW-1:0]       sram_wdata_o,
    input  logic [MW-1:0]       sram_rdata_i,
    output logic                busy_o
);

    localparam int                NB    = DATA_W / 8;
    localparam logic [ADDR_W-1:0] DEPTH = ADDR_W'(1) << SRAM_AW;
    localparam logic [1:0]        LAST  = 2'(SRAM_LAT - 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   off, off_words;
    logic                req_err;
    logic [MW-1:0]       wmask_d, wdata_d;
    logic [DATA_W-1:0]   rmask, rdata_m;
    logic                par_err;
    logic                we_q, err_q, perr_q;
    logic [NB-1:0]       be_q;
    logic [1:0]          cnt_q;
    logic [DATA_W-1:0]   rdata_q;
    logic                sram_ce_q, sram_we_q;
    logic [SRAM_AW-1:0]  sram_addr_q;
    logic [MW-1:0]       sram_wmask_q, sram_wdata_q;

    // Offset from the SRAM base and request legality; addresses below the
    // base wrap to huge offsets and fall out of range.
    always_comb begin
        off       = addr_i - BASE_ADDR;
        off_words = off >> 2;
        req_err   = (addr_i[1:0] != 2'b00) || (off_words >= DEPTH) || (be_i == '0);
    end

    // Byte enables expanded to a bit mask; parity bits ride above the data.
    always_comb begin
        wmask_d = '0;
        wdata_d = '0;
        wdata_d[DATA_W-1:0] = wdata_i;
        for (int i = 0; i < NB; i++) begin
            wmask_d[8*i +: 8] = {8{be_i[i]}};
`ifdef SRAM_BRIDGE_PARITY_EN
            wmask_d[DATA_W+i] = be_i[i];
            wdata_d[DATA_W+i] = ^wdata_i[8*i +: 8];
`endif
        end
    end

    // Zero disabled bytes of the returned word and check parity of enabled ones.
    always_comb begin
        rmask   = '0;
        par_err = 1'b0;
        for (int i = 0; i < NB; i++) begin
            rmask[8*i +: 8] = {8{be_q[i]}};
`ifdef SRAM_BRIDGE_PARITY_EN
            if (be_q[i] && ((^sram_rdata_i[8*i +: 8]) != sram_rdata_i[DATA_W+i]))
                par_err = 1'b1;
`endif
        end
        rdata_m = sram_rdata_i[DATA_W-1:0] & rmask;
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    // Next state: errors skip the macro, writes skip the latency wait.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (req_i) state_d = req_err ? S_RESP : S_ISSUE;
            S_ISSUE: state_d = we_q ? S_RESP : S_WAIT;
            S_WAIT:  if (cnt_q == LAST) state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Request capture, registered macro drive (live only during ISSUE),
    // latency counter and read-data capture at the end of the last wait cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            we_q         <= 1'b0;
            be_q         <= '0;
            err_q        <= 1'b0;
            perr_q       <= 1'b0;
            rdata_q      <= '0;
            cnt_q        <= '0;
            sram_ce_q    <= 1'b0;
            sram_we_q    <= 1'b0;
            sram_addr_q  <= '0;
            sram_wmask_q <= '0;
            sram_wdata_q <= '0;
        end else begin
            if (gnt_o) begin
                we_q    <= we_i;
                be_q    <= be_i;
                err_q   <= req_err;
                perr_q  <= 1'b0;
                rdata_q <= '0;
            end
            if (gnt_o && !req_err) begin
                sram_ce_q    <= 1'b1;
                sram_we_q    <= we_i;
                sram_addr_q  <= off_words[SRAM_AW-1:0];
                sram_wmask_q <= wmask_d;
                sram_wdata_q <= wdata_d;
            end else begin
                sram_ce_q    <= 1'b0;
                sram_we_q    <= 1'b0;
                sram_addr_q  <= '0;
                sram_wmask_q <= '0;
                sram_wdata_q <= '0;
            end
            if (state_q == S_ISSUE)     cnt_q <= '0;
            else if (state_q == S_WAIT) cnt_q <= cnt_q + 2'd1;
            if (state_q == S_WAIT && cnt_q == LAST) begin
                rdata_q <= rdata_m;
                perr_q  <= par_err;
            end
        end
    end

    assign gnt_o        = req_i && rst && (state_q == S_IDLE);
    assign busy_o       = (state_q != S_IDLE);
    assign rvalid_o     = (state_q == S_RESP);
    assign err_o        = (state_q == S_RESP) && (err_q || perr_q);
    assign rdata_o      = (state_q == S_RESP) ? rdata_q : '0;
    assign sram_ce_o    = sram_ce_q;
    assign sram_we_o    = sram_we_q;
    assign sram_addr_o  = sram_addr_q;
    assign sram_wmask_o = sram_wmask_q;
    assign sram_wdata_o = sram_wdata_q;

endmodule

// File: tb/tb_sram_bridge.sv
// tb_sram_bridge: directed bench for sram_bridge with an SRAM macro model,
// a transaction-level reference model and a per-cycle compare process.
module tb_sram_bridge;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int SRAM_AW = 10;
  localparam int LAT     = 1;
  localparam int DEPTH   = 1024;
  localparam logic [31:0] BASE = 32'h0;
`ifdef SRAM_BRIDGE_PARITY_EN
  localparam int MW = DATA_W + DATA_W/8;
`else
  localparam int MW = DATA_W;
`endif

  logic               clk = 1'b0;
  logic               rst;
  logic               req_i, we_i;
  logic               gnt_o, rvalid_o, err_o, sram_ce_o, sram_we_o, busy_o;
  logic [ADDR_W-1:0]  addr_i;
  logic [3:0]         be_i;
  logic [DATA_W-1:0]  wdata_i, rdata_o;
  logic [SRAM_AW-1:0] sram_addr_o;
  logic [MW-1:0]      sram_wmask_o, sram_wdata_o, sram_rdata_i;

  sram_bridge #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SRAM_AW(SRAM_AW),
                .BASE_ADDR(BASE), .SRAM_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .req_i(req_i), .gnt_o(gnt_o), .addr_i(addr_i),
    .we_i(we_i), .be_i(be_i), .wdata_i(wdata_i), .rvalid_o(rvalid_o),
    .err_o(err_o), .rdata_o(rdata_o), .sram_ce_o(sram_ce_o),
    .sram_we_o(sram_we_o), .sram_addr_o(sram_addr_o),
    .sram_wmask_o(sram_wmask_o), .sram_wdata_o(sram_wdata_o),
    .sram_rdata_i(sram_rdata_i), .busy_o(busy_o));

  // ---------------- clock / reset / cycle counter ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- SRAM macro model ----------------
  logic          mem_clr;
  logic          flip_req;
  logic [MW-1:0] mem [DEPTH];
  logic [MW-1:0] rpipe [LAT];

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (sram_ce_o && sram_we_o) begin
      mem[sram_addr_o] <= (mem[sram_addr_o] & ~sram_wmask_o) | (sram_wdata_o & sram_wmask_o);
    end
`ifdef SRAM_BRIDGE_PARITY_EN
    if (flip_req) mem[4][DATA_W] <= ~mem[4][DATA_W];
`endif
    rpipe[0] <= (sram_ce_o && !sram_we_o) ? mem[sram_addr_o] : '0;
    for (int i = 1; i < LAT; i++) rpipe[i] <= rpipe[i-1];
  end
  assign sram_rdata_i = rpipe[LAT-1];

  // ---------------- reference model ----------------
  function automatic logic [MW-1:0] byte_mask(input logic [3:0] b);
    logic [MW-1:0] m;
    m = '0;
    for (int i = 0; i < 4; i++) begin
      if (b[i]) m[8*i +: 8] = 8'hFF;
`ifdef SRAM_BRIDGE_PARITY_EN
      m[DATA_W+i] = b[i];
`endif
    end
    return m;
  endfunction

  function automatic logic [MW-1:0] with_par(input logic [31:0] d);
    logic [MW-1:0] w;
    w = '0;
    w[31:0] = d;
`ifdef SRAM_BRIDGE_PARITY_EN
    for (int i = 0; i < 4; i++) w[DATA_W+i] = ^d[8*i +: 8];
`endif
    return w;
  endfunction

  logic [MW-1:0]      ref_mem [DEPTH] = '{default: '0};
  int                 free_at = 0;
  int                 rv_cyc_q[$];
  logic               rv_err_q[$];
  logic [DATA_W-1:0]  exp_q[$];
  int                 ce_cyc_q[$];
  logic               ce_we_q[$];
  logic [SRAM_AW-1:0] ce_addr_q[$];
  logic [MW-1:0]      ce_mask_q[$];
  logic [MW-1:0]      ce_data_q[$];

  // observation records used by the literal checks
  int                 last_gnt_cyc = 0, last_rv_cyc = 0, rv_count = 0, ce_count = 0;
  logic [DATA_W-1:0]  last_rdata = '0;
  logic               last_err = 1'b0;
  logic [SRAM_AW-1:0] last_ce_addr = '0;

  // model scratch
  logic [31:0]   m_off;
  logic          m_err, m_perr, exp_gnt, exp_busy, exp_rv, exp_ce;
  int            m_idx;
  logic [MW-1:0] m_mask, m_word;

  // ---------------- compare process ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("reset_outputs", |{gnt_o, rvalid_o, err_o, rdata_o, sram_ce_o, sram_we_o,
                                sram_addr_o, sram_wmask_o, sram_wdata_o, busy_o}, 1'b0);
        rv_cyc_q.delete(); rv_err_q.delete(); exp_q.delete();
        ce_cyc_q.delete(); ce_we_q.delete(); ce_addr_q.delete();
        ce_mask_q.delete(); ce_data_q.delete();
        free_at = cyc + 1;
`ifdef SRAM_BRIDGE_PARITY_EN
        if (flip_req) ref_mem[4][DATA_W] = ~ref_mem[4][DATA_W];
`endif
      end else begin
`ifdef SRAM_BRIDGE_PARITY_EN
        if (flip_req) ref_mem[4][DATA_W] = ~ref_mem[4][DATA_W];
`endif
        exp_busy = (cyc < free_at);
        exp_gnt  = req_i && !exp_busy;
        chk("gnt", gnt_o, exp_gnt);
        chk("busy", busy_o, exp_busy);
        if (exp_gnt) begin
          m_off  = addr_i - BASE;
          m_err  = (addr_i[1:0] != 2'b00) || ((m_off >> 2) >= 32'(DEPTH)) || (be_i == 4'h0);
          m_idx  = int'(m_off[11:2]);
          m_mask = byte_mask(be_i);
          if (m_err) begin
            rv_cyc_q.push_back(cyc + 1); rv_err_q.push_back(1'b1); exp_q.push_back('0);
            free_at = cyc + 2;
          end else begin
            ce_cyc_q.push_back(cyc + 1); ce_we_q.push_back(we_i);
            ce_addr_q.push_back(m_off[11:2]); ce_mask_q.push_back(m_mask);
            ce_data_q.push_back(with_par(wdata_i));
            if (we_i) begin
              ref_mem[m_idx] = (ref_mem[m_idx] & ~m_mask) | (with_par(wdata_i) & m_mask);
              rv_cyc_q.push_back(cyc + 2); rv_err_q.push_back(1'b0); exp_q.push_back('0);
              free_at = cyc + 3;
            end else begin
              m_word = ref_mem[m_idx];
              m_perr = 1'b0;
`ifdef SRAM_BRIDGE_PARITY_EN
              for (int b = 0; b < 4; b++)
                if (be_i[b] && ((^m_word[8*b +: 8]) != m_word[DATA_W+b])) m_perr = 1'b1;
`endif
              rv_cyc_q.push_back(cyc + 2 + LAT); rv_err_q.push_back(m_perr);
              exp_q.push_back(m_word[31:0] & m_mask[31:0]);
              free_at = cyc + 3 + LAT;
            end
          end
        end
        exp_rv = (rv_cyc_q.size() != 0) && (rv_cyc_q[0] == cyc);
        chk("rvalid", rvalid_o, exp_rv);
        if (exp_rv) begin
          chk("err", err_o, rv_err_q[0]);
          chk("rdata", rdata_o, exp_q[0]);
          void'(rv_cyc_q.pop_front()); void'(rv_err_q.pop_front()); void'(exp_q.pop_front());
        end
        exp_ce = (ce_cyc_q.size() != 0) && (ce_cyc_q[0] == cyc);
        chk("sram_ce", sram_ce_o, exp_ce);
        if (exp_ce) begin
          chk("sram_we", sram_we_o, ce_we_q[0]);
          chk("sram_addr", sram_addr_o, ce_addr_q[0]);
          if (ce_we_q[0]) begin
            chk("sram_wmask", sram_wmask_o, ce_mask_q[0]);
            chk("sram_wdata", sram_wdata_o & ce_mask_q[0], ce_data_q[0] & ce_mask_q[0]);
          end
          void'(ce_cyc_q.pop_front()); void'(ce_we_q.pop_front()); void'(ce_addr_q.pop_front());
          void'(ce_mask_q.pop_front()); void'(ce_data_q.pop_front());
        end else begin
          chk("sram_idle", |{sram_ce_o, sram_we_o, sram_addr_o, sram_wmask_o, sram_wdata_o}, 1'b0);
        end
        if (gnt_o) last_gnt_cyc = cyc;
        if (rvalid_o) begin
          rv_count++; last_rv_cyc = cyc; last_rdata = rdata_o; last_err = err_o;
        end
        if (sram_ce_o) begin
          ce_count++; last_ce_addr = sram_addr_o;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_req(input logic [31:0] a, input logic w, input logic [3:0] b,
                        input logic [31:0] d, input bit hold);
    bit got;
    req_i = 1'b1; addr_i = a; we_i = w; be_i = b; wdata_i = d;
    got = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (gnt_o) begin got = 1'b1; break; end
    end
    if (!got) chk("grant_timeout", 1'b0, 1'b1);
    @(posedge clk); #1;
    if (!hold) begin
      req_i = 1'b0; addr_i = $urandom; we_i = 1'($urandom_range(0, 1));
      be_i = 4'($urandom_range(0, 15)); wdata_i = $urandom;
    end
  endtask

  task automatic wait_done();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (rv_cyc_q.size() == 0 && ce_cyc_q.size() == 0) begin ok = 1'b1; break; end
    end
    if (!ok) chk("response_timeout", 1'b0, 1'b1);
    @(posedge clk); #1;
  endtask

  task automatic rd(input logic [31:0] a, input logic [3:0] b);
    do_req(a, 1'b0, b, 32'h0, 1'b0);
    wait_done();
  endtask

  task automatic wr(input logic [31:0] a, input logic [3:0] b, input logic [31:0] d);
    do_req(a, 1'b1, b, d, 1'b0);
    wait_done();
  endtask

  // ---------------- stimulus ----------------
  int g1, g2, g3, n0;

  initial begin
    rst = 1'b0; req_i = 1'b0; addr_i = '0; we_i = 1'b0; be_i = '0; wdata_i = '0;
    flip_req = 1'b0; mem_clr = 1'b1;
    repeat (3) @(posedge clk);
    #1; mem_clr = 1'b0; rst = 1'b1;

    // full-word write then read
    wr(32'h10, 4'hF, 32'hDEADBEEF);
    rd(32'h10, 4'hF);
    chk("lit_rd_data", last_rdata, 32'hDEADBEEF);
    chk("lit_rd_err", last_err, 1'b0);
    chk("lit_rd_latency", last_rv_cyc - last_gnt_cyc, 3);
    chk("lit_rd_sram_addr", last_ce_addr, 10'd4);

    // partial write, full and partial reads
    wr(32'h10, 4'b0010, 32'h0000AB00);
    rd(32'h10, 4'hF);
    chk("lit_merge_full", last_rdata, 32'hDEADABEF);
    rd(32'h10, 4'b0001);
    chk("lit_merge_byte0", last_rdata, 32'h000000EF);

    // error requests never touch the macro
    n0 = ce_count;
    rd(32'h12, 4'hF);
    chk("lit_misaligned_err", last_err, 1'b1);
    chk("lit_err_latency", last_rv_cyc - last_gnt_cyc, 1);
    chk("lit_err_rdata", last_rdata, 32'h0);
    wr(32'h1000, 4'hF, 32'h11111111);
    chk("lit_range_err", last_err, 1'b1);
    rd(32'h20, 4'h0);
    chk("lit_be0_err", last_err, 1'b1);
    chk("lit_err_no_ce", ce_count - n0, 0);

    // last legal word
    wr(32'hFFC, 4'hF, 32'h12345678);
    chk("lit_top_sram_addr", last_ce_addr, 10'h3FF);
    rd(32'hFFC, 4'hF);
    chk("lit_top_data", last_rdata, 32'h12345678);

    // back-to-back writes with req held high
    n0 = rv_count;
    do_req(32'h20, 1'b1, 4'hF, 32'hA1A1A1A1, 1'b1); g1 = last_gnt_cyc;
    do_req(32'h24, 1'b1, 4'hF, 32'hB2B2B2B2, 1'b1); g2 = last_gnt_cyc;
    do_req(32'h28, 1'b1, 4'hF, 32'hC3C3C3C3, 1'b0); g3 = last_gnt_cyc;
    wait_done();
    chk("lit_b2b_gap1", g2 - g1, 3);
    chk("lit_b2b_gap2", g3 - g2, 3);
    chk("lit_b2b_resp_count", rv_count - n0, 3);
    rd(32'h24, 4'hF);
    chk("lit_b2b_data", last_rdata, 32'hB2B2B2B2);

    // request withdrawn before it could be granted
    do_req(32'h10, 1'b0, 4'hF, 32'h0, 1'b0);
    req_i = 1'b1; addr_i = 32'h30; we_i = 1'b1; be_i = 4'hF; wdata_i = 32'h55555555;
    @(posedge clk); #1;
    req_i = 1'b0;
    wait_done();
    chk("lit_withdraw_rd", last_rdata, 32'hDEADABEF);
    rd(32'h30, 4'hF);
    chk("lit_withdraw_nowrite", last_rdata, 32'h0);

    // reset while the macro is enabled, then while waiting for read data
    n0 = rv_count;
    do_req(32'h10, 1'b0, 4'hF, 32'h0, 1'b0);
    rst = 1'b0; #1;
    chk("async_reset_issue", |{sram_ce_o, busy_o, rvalid_o}, 1'b0);
    repeat (2) @(posedge clk); #1; rst = 1'b1;
    do_req(32'h10, 1'b0, 4'hF, 32'h0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0; #1;
    chk("async_reset_wait", |{sram_ce_o, busy_o, rvalid_o, rdata_o}, 1'b0);
    repeat (2) @(posedge clk); #1; rst = 1'b1;
    repeat (4) @(posedge clk); #1;
    chk("lit_reset_no_resp", rv_count - n0, 0);
    rd(32'h10, 4'hF);
    chk("lit_after_reset", last_rdata, 32'hDEADABEF);

`ifdef SRAM_BRIDGE_PARITY_EN
    // corrupted parity on byte 0
    wr(32'h10, 4'hF, 32'hDEADBEEF);
    flip_req = 1'b1;
    @(posedge clk); #1;
    flip_req = 1'b0;
    rd(32'h10, 4'hF);
    chk("lit_par_err", last_err, 1'b1);
    chk("lit_par_data", last_rdata, 32'hDEADBEEF);
    rd(32'h10, 4'b1110);
    chk("lit_par_masked_err", last_err, 1'b0);
    chk("lit_par_masked_data", last_rdata, 32'hDEADBE00);
`endif

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule
